// File: rtl/regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_sb_pkg
// Shared constants and types for the scoreboarded register file.
//   DEFAULT_DATA_W / DEFAULT_NUM_REGS : default geometry of the GPR file
//   ZERO_WORD                         : all-zero data word
//   REG_ZERO_ADDR                     : address of the hard-wired zero register
//   reg_addr_t                        : register address sized for the default depth
// ---------------------------------------------------------------------------
package regfile_sb_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_AW       = $clog2(DEFAULT_NUM_REGS);

  localparam logic [DEFAULT_DATA_W-1:0] ZERO_WORD     = '0;
  localparam logic [DEFAULT_AW-1:0]     REG_ZERO_ADDR = '0;

  typedef logic [DEFAULT_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Per-register pending-write tracker. A register becomes busy when an
// instruction writing it issues and is released when its writeback arrives.
//   CLK, RST      : clock, synchronous active-high reset
//   i_wr_vld      : per write port, write is enabled and actually lands
//   i_waddr       : write addresses, NUM_WR x AW packed
//   i_issue_en    : mark i_issue_addr pending
//   i_issue_addr  : destination of the issued instruction
//   i_flush       : clear every pending mark
//   o_busy        : busy vector, one bit per register
//   o_busy_cnt    : registered number of busy registers
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_WR   = 1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_WR-1:0]    i_wr_vld,
  input  logic [NUM_WR*AW-1:0] i_waddr,
  input  logic                 i_issue_en,
  input  logic [AW-1:0]        i_issue_addr,
  input  logic                 i_flush,
  output logic [NUM_REGS-1:0]  o_busy,
  output logic [AW:0]          o_busy_cnt
);

  localparam int CW = AW + 1;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [CW-1:0]       r_busy_cnt;
  logic [CW-1:0]       w_cnt_nxt;

  // Priority is encoded by assignment order: clear, then issue, then flush,
  // so each later rule overrides the earlier ones.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_wr_vld[w] && (i_waddr[w*AW +: AW] == AW'(i))) begin
          w_busy_nxt[i] = 1'b0;
        end
      end
    end
    // Issue beats a same-cycle writeback: that write belongs to the older producer.
    if (i_issue_en && !(ZERO_REG && (i_issue_addr == AW'(REG_ZERO_ADDR)))) begin
      w_busy_nxt[i_issue_addr] = 1'b1;
    end
    if (i_flush) begin
      w_busy_nxt = '0;
    end

    // Count the next state so the registered count lines up with busy itself.
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Multi-port register file with write-through bypass and a pending-write
// scoreboard for decode-stage stall detection.
//   CLK, RST    : clock, synchronous active-high reset
//   WEN/WADDR/WDATA : NUM_WR write ports (packed, port 0 in the LSBs)
//   REN/RADDR   : NUM_RD read ports
//   RDATA       : combinational read data, bypassed from same-cycle writes
//   RBUSY       : read target still awaits its writeback
//   ISSUE_EN/ISSUE_ADDR : mark a destination register pending
//   FLUSH       : drop every pending mark
//   BUSY_CNT    : registered count of pending registers
// ---------------------------------------------------------------------------
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_WR-1:0]        WEN,
  input  logic [NUM_WR*AW-1:0]     WADDR,
  input  logic [NUM_WR*DATA_W-1:0] WDATA,
  input  logic [NUM_RD-1:0]        REN,
  input  logic [NUM_RD*AW-1:0]     RADDR,
  output logic [NUM_RD*DATA_W-1:0] RDATA,
  output logic [NUM_RD-1:0]        RBUSY,
  input  logic                     ISSUE_EN,
  input  logic [AW-1:0]            ISSUE_ADDR,
  input  logic                     FLUSH,
  output logic [AW:0]              BUSY_CNT
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_WR-1:0]   w_wr_vld;
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_RD-1:0]   w_hit;
  logic [DATA_W-1:0]   w_byp [NUM_RD];

  // A write to the zero register is dropped everywhere: array, bypass and scoreboard.
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      w_wr_vld[w] = WEN[w] && !(ZERO_REG && (WADDR[w*AW +: AW] == AW'(REG_ZERO_ADDR)));
    end
  end

  // NOTE: the array is reset explicitly because reads after reset must return
  // zero; this keeps it in flops rather than a RAM macro.
  // Ascending port order lets the highest-index port win a same-address write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= DATA_W'(ZERO_WORD);
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (w_wr_vld[w]) begin
          r_regs[WADDR[w*AW +: AW]] <= WDATA[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Bypass: find the highest-index enabled write hitting each read address.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      w_hit[r] = 1'b0;
      w_byp[r] = DATA_W'(ZERO_WORD);
      for (int w = 0; w < NUM_WR; w++) begin
        if (w_wr_vld[w] && (WADDR[w*AW +: AW] == RADDR[r*AW +: AW])) begin
          w_hit[r] = 1'b1;
          w_byp[r] = WDATA[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // A bypass hit means the producer is writing back right now, so it is not busy.
  always_comb begin
    RDATA = '0;
    RBUSY = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (!RST && REN[r] &&
          !(ZERO_REG && (RADDR[r*AW +: AW] == AW'(REG_ZERO_ADDR)))) begin
        RDATA[r*DATA_W +: DATA_W] = w_hit[r] ? w_byp[r] : r_regs[RADDR[r*AW +: AW]];
        RBUSY[r]                  = w_busy[RADDR[r*AW +: AW]] && !w_hit[r];
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .CLK          (CLK),
    .RST          (RST),
    .i_wr_vld     (w_wr_vld),
    .i_waddr      (WADDR),
    .i_issue_en   (ISSUE_EN),
    .i_issue_addr (ISSUE_ADDR),
    .i_flush      (FLUSH),
    .o_busy       (w_busy),
    .o_busy_cnt   (BUSY_CNT)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Self-checking bench for regfile_sb with 2 read and 2 write ports.
// A behavioural model (plain arrays) tracks register contents and pending
// marks; every cycle the DUT outputs are compared against it, plus directed
// checks against fixed constants.
// ---------------------------------------------------------------------------
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;

  logic               CLK = 1'b0;
  logic               RST;
  logic [NWR-1:0]     WEN;
  logic [NWR*AW-1:0]  WADDR;
  logic [NWR*DW-1:0]  WDATA;
  logic [NRD-1:0]     REN;
  logic [NRD*AW-1:0]  RADDR;
  logic [NRD*DW-1:0]  RDATA;
  logic [NRD-1:0]     RBUSY;
  logic               ISSUE_EN;
  reg_addr_t          ISSUE_ADDR;
  logic               FLUSH;
  logic [AW:0]        BUSY_CNT;

  always #5 CLK = ~CLK;

  regfile_sb #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR),
    .ZERO_REG (1'b1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WEN        (WEN),
    .WADDR      (WADDR),
    .WDATA      (WDATA),
    .REN        (REN),
    .RADDR      (RADDR),
    .RDATA      (RDATA),
    .RBUSY      (RBUSY),
    .ISSUE_EN   (ISSUE_EN),
    .ISSUE_ADDR (ISSUE_ADDR),
    .FLUSH      (FLUSH),
    .BUSY_CNT   (BUSY_CNT)
  );

  // Reference state
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rdata(input int r);
    int a;
    logic [DW-1:0] v;
    a = int'(RADDR[r*AW +: AW]);
    if (RST || !REN[r] || a == 0) return '0;
    v = m_regs[a];
    for (int w = 0; w < NWR; w++)
      if (WEN[w] && int'(WADDR[w*AW +: AW]) == a) v = WDATA[w*DW +: DW];
    return v;
  endfunction

  function automatic bit exp_rbusy(input int r);
    int a;
    a = int'(RADDR[r*AW +: AW]);
    if (RST || !REN[r] || a == 0) return 1'b0;
    for (int w = 0; w < NWR; w++)
      if (WEN[w] && int'(WADDR[w*AW +: AW]) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Apply the architectural effect of one clock edge to the model.
  task automatic model_edge();
    int a;
    if (RST) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        a = int'(WADDR[w*AW +: AW]);
        if (WEN[w] && a != 0) m_regs[a] = WDATA[w*DW +: DW];
      end
      if (FLUSH) begin
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      end else begin
        for (int w = 0; w < NWR; w++)
          if (WEN[w]) m_busy[int'(WADDR[w*AW +: AW])] = 1'b0;
        if (ISSUE_EN && ISSUE_ADDR != 0) m_busy[int'(ISSUE_ADDR)] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    WEN = '0; WADDR = '0; WDATA = '0;
    REN = '0; RADDR = '0;
    ISSUE_EN = 1'b0; ISSUE_ADDR = '0; FLUSH = 1'b0;
  endtask

  task automatic set_wr(input int w, input int a, input logic [DW-1:0] d);
    WEN[w] = 1'b1;
    WADDR[w*AW +: AW] = AW'(a);
    WDATA[w*DW +: DW] = d;
  endtask

  task automatic set_rd(input int r, input int a);
    REN[r] = 1'b1;
    RADDR[r*AW +: AW] = AW'(a);
  endtask

  task automatic issue(input int a);
    ISSUE_EN = 1'b1;
    ISSUE_ADDR = reg_addr_t'(a);
  endtask

  // Compare all outputs against the model mid-cycle, then take one edge.
  task automatic run_cycle(input string tag);
    #1;
    for (int r = 0; r < NRD; r++) begin
      check($sformatf("%s rdata%0d", tag, r), 64'(RDATA[r*DW +: DW]), 64'(exp_rdata(r)));
      check($sformatf("%s rbusy%0d", tag, r), 64'(RBUSY[r]), 64'(exp_rbusy(r)));
    end
    check($sformatf("%s busy_cnt", tag), 64'(BUSY_CNT), 64'(exp_cnt()));
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  function automatic int rnd_addr();
    return $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NR-1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    idle();
    RST = 1'b1;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    RST = 1'b0;

    // Reset: fill, reset with a write in flight, then read everything back.
    for (int i = 1; i < NR; i++) begin
      idle(); set_wr(0, i, $urandom); set_wr(1, NR-i, $urandom); issue(i);
      run_cycle("fill");
    end
    idle(); RST = 1'b1; set_wr(0, 3, 32'hCAFE_F00D); set_rd(0, 3);
    run_cycle("rst");
    RST = 1'b0;
    for (int i = 0; i < NR; i++) begin
      idle(); set_rd(0, i); set_rd(1, NR-1-i);
      #1;
      check("post_rst rdata0", 64'(RDATA[DW-1:0]), 64'h0);
      check("post_rst busy_cnt", 64'(BUSY_CNT), 64'h0);
      run_cycle("post_rst");
    end

    // Bypass: same-cycle read-after-write, and the value persists.
    idle(); set_wr(0, 5, 32'hDEAD_BEEF); set_rd(0, 5);
    #1 check("bypass same", 64'(RDATA[DW-1:0]), 64'hDEAD_BEEF);
    run_cycle("bypass");
    idle(); set_rd(0, 5);
    #1 check("bypass next", 64'(RDATA[DW-1:0]), 64'hDEAD_BEEF);
    run_cycle("bypass_next");

    // Zero register ignores writes and issues.
    idle(); set_wr(0, 0, 32'h1234); set_rd(0, 0);
    run_cycle("zero_wr");
    idle(); set_rd(0, 0);
    #1 check("zero read", 64'(RDATA[DW-1:0]), 64'h0);
    run_cycle("zero_rd");
    idle(); issue(0);
    run_cycle("zero_issue");
    idle();
    #1 check("zero issue cnt", 64'(BUSY_CNT), 64'h0);
    run_cycle("zero_issue_after");

    // Write conflict: port 1 wins.
    idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7);
    #1 check("conflict bypass", 64'(RDATA[DW-1:0]), 64'h22);
    run_cycle("conflict");
    idle(); set_rd(1, 7);
    #1 check("conflict stored", 64'(RDATA[2*DW-1:DW]), 64'h22);
    run_cycle("conflict_after");

    // Scoreboard set / clear / issue-beats-writeback.
    idle(); issue(9);
    run_cycle("sb_issue");
    idle(); set_rd(0, 9);
    #1;
    check("sb rbusy set", 64'(RBUSY[0]), 64'h1);
    check("sb cnt set", 64'(BUSY_CNT), 64'h1);
    run_cycle("sb_busy");
    idle(); set_wr(0, 9, 32'h99); set_rd(0, 9);
    #1 check("sb wb rbusy", 64'(RBUSY[0]), 64'h0);
    run_cycle("sb_wb");
    idle();
    #1 check("sb cnt clear", 64'(BUSY_CNT), 64'h0);
    run_cycle("sb_clear");
    idle(); issue(9); set_wr(1, 9, 32'h98);
    run_cycle("sb_both");
    idle(); set_rd(0, 9);
    #1;
    check("sb both rbusy", 64'(RBUSY[0]), 64'h1);
    check("sb both cnt", 64'(BUSY_CNT), 64'h1);
    run_cycle("sb_both_after");
    idle(); set_wr(0, 9, 32'h97);
    run_cycle("sb_release");

    // Flush beats a same-cycle issue.
    for (int i = 3; i <= 5; i++) begin
      idle(); issue(i);
      run_cycle("fl_issue");
    end
    idle(); FLUSH = 1'b1; issue(6);
    #1 check("fl cnt before", 64'(BUSY_CNT), 64'h3);
    run_cycle("flush");
    idle(); set_rd(0, 6); set_rd(1, 3);
    #1;
    check("fl cnt", 64'(BUSY_CNT), 64'h0);
    check("fl rbusy6", 64'(RBUSY[0]), 64'h0);
    check("fl rbusy3", 64'(RBUSY[1]), 64'h0);
    run_cycle("flush_after");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      idle();
      RST = ($urandom_range(0, 99) == 0);
      for (int w = 0; w < NWR; w++)
        if ($urandom_range(0, 1) == 1) set_wr(w, rnd_addr(), $urandom);
      for (int r = 0; r < NRD; r++)
        if ($urandom_range(0, 3) != 0) set_rd(r, rnd_addr());
      if ($urandom_range(0, 2) == 0) issue(rnd_addr());
      FLUSH = ($urandom_range(0, 49) == 0);
      run_cycle("rand");
    end
    RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
